mul_wb_stage: RTL and testbench
===============================

MUL_WB_STAGE -- requirements
Module: mul_wb_stage

Interface
REQ-001 SHALL have parameter P_BASE_ADDR, default 5'd0: register-file address that receives the low product byte; the high byte goes to P_BASE_ADDR+1, modulo 32.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst, input, 1, reset: asynchronous and active-high.
REQ-004 SHALL have port i_valid, input, 1: the upstream fractional multiplier presents a product.
REQ-005 SHALL have port o_ready, output, 1: the stage accepts a product this cycle.
REQ-006 SHALL have port i_r1, input, 8: high product byte.
REQ-007 SHALL have port i_r0, input, 8: low product byte.
REQ-008 SHALL have port i_c, input, 1: carry, which is bit 15 of the raw 16-bit product.
REQ-009 SHALL have port o_we, output, 1: register-file write enable.
REQ-010 SHALL have port o_waddr, output, 5: register-file write address.
REQ-011 SHALL have port o_wdata, output, 8: register-file write data.
REQ-012 SHALL have port o_flag_we, output, 1: one-cycle strobe that commits the flags.
REQ-013 SHALL have port o_c, output, 1: registered carry flag.
REQ-014 SHALL have port o_z, output, 1: registered zero flag.
REQ-015 SHALL have port o_done, output, 1: one-cycle pulse when a product has been fully written back.

Function
REQ-016 SHALL implement a state machine with three states: IDLE, WR0 and WR1.
REQ-017 A handshake SHALL occur when i_valid and o_ready are both 1 at a rising edge; at that edge the stage captures i_r1, i_r0 and i_c.
REQ-018 On a handshake in IDLE, the state SHALL go IDLE->WR0.
- WR0 always goes to WR1.
- WR1 goes to IDLE, or to WR0 if the skid buffer holds a product (see REQ-028).
REQ-019 In WR0 the stage SHALL drive o_we=1, o_waddr=P_BASE_ADDR and o_wdata=captured r0.
REQ-020 In WR1 the stage SHALL drive o_we=1, o_waddr=P_BASE_ADDR+1, o_wdata=captured r1, o_flag_we=1 and o_done=1.
REQ-021 In IDLE, o_we, o_flag_we and o_done SHALL be 0, and o_waddr and o_wdata SHALL be 0.
REQ-022 o_z and o_c SHALL update at the rising edge that ends WR1 and SHALL hold between updates.
- o_z = ({r1,r0} == 16'h0000).
- o_c = captured c.
REQ-023 Latency SHALL be fixed: the low byte is written in the first cycle after the handshake and the high byte in the second.
REQ-024 o_ready SHALL be combinational from state only (REQ-027, REQ-028), with no dependency on i_valid.
REQ-025 Input data SHALL be ignored when no handshake occurs; i_valid dropping mid-writeback SHALL NOT affect the writeback.

Reset
REQ-026 Asserting i_rst at any time SHALL, without waiting for a clock edge:
- force the state to IDLE and abort any writeback in progress;
- clear the captured data and the skid buffer;
- drive o_we=0, o_flag_we=0, o_done=0, o_c=0, o_z=0, o_waddr=0 and o_wdata=0;
- hold o_ready=0 while i_rst is 1 and release it the cycle after deassertion.

Configuration
REQ-027 Without MUL_WB_SKID_EN defined, o_ready SHALL be 1 only in IDLE, so throughput is at most one product every three cycles.
REQ-028 With MUL_WB_SKID_EN defined:
- the stage SHALL include a one-entry skid buffer, and o_ready SHALL be 1 whenever that buffer is empty.
- A handshake in WR0 or WR1 SHALL load the skid buffer.
- WR1 with the skid buffer full SHALL go to WR0 using the skid contents and empty the buffer in the same edge.
- This gives back-to-back throughput of one product every two cycles.

Verification
REQ-029 Single product: r1=8'h40, r0=8'h80, c=0 -> WR0 writes addr 0 data 8'h80; WR1 writes addr 1 data 8'h40; o_done=1, o_z=0, o_c=0.
REQ-030 Zero product: r1=0, r0=0, c=1 -> two writes of 8'h00; after WR1, o_z=1 and o_c=1; both flags hold through a later idle period.
REQ-031 Back-pressure: i_valid held high for 3 products.
- Without the macro: o_ready=0 in WR0 and WR1, and done pulses arrive 3 cycles apart.
- With MUL_WB_SKID_EN: done pulses arrive 2 cycles apart, with no lost or duplicated write.
REQ-032 Reset mid-operation: assert i_rst in WR0 after accepting r0=8'hFF -> o_we drops immediately, no write to addr 1 occurs, flags read 0, and the next product writes correctly.
REQ-033 Address wrap: P_BASE_ADDR=5'd31, one product -> writes go to addr 31, then addr 0.

Source files
------------

// File: rtl/mul_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mul_wb_stage
// Brief    : Writeback stage for a fractional multiplier. Writes the 16-bit
//            product as two register-file bytes (low, then high) and commits
//            the carry/zero flags with the high-byte write.
//            Optional feature macro: MUL_WB_SKID_EN (one-entry skid buffer,
//            one product every two cycles when back-to-back).
// Revision : 1.0 - initial release
// ============================================================================
module mul_wb_stage #(
  parameter logic [4:0] P_BASE_ADDR = 5'd0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [7:0] i_r1,
  input  logic [7:0] i_r0,
  input  logic       i_c,
  output logic       o_we,
  output logic [4:0] o_waddr,
  output logic [7:0] o_wdata,
  output logic       o_flag_we,
  output logic       o_c,
  output logic       o_z,
  output logic       o_done
);

  localparam logic [4:0] C_ADDR_LO = P_BASE_ADDR;
  // 5-bit sum wraps 31 -> 0 naturally
  localparam logic [4:0] C_ADDR_HI = P_BASE_ADDR + 5'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR0  = 2'd1,
    S_WR1  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        rdy_en_q;            // keeps o_ready low until the first edge after reset
  logic [16:0] prod_q, prod_d;      // {c, r1, r0} of the product being written
  logic        c_q, z_q;
  logic        w_hs;

`ifdef MUL_WB_SKID_EN
  logic        skid_vld_q, skid_vld_d;
  logic [16:0] skid_q, skid_d;

  // Accept whenever the skid slot is free; the main register drains it.
  assign o_ready = rdy_en_q && !skid_vld_q;
`else
  // Without the skid slot, only an idle stage can take a new product.
  assign o_ready = rdy_en_q && (state_q == S_IDLE);
`endif

  assign w_hs = i_valid && o_ready;

  // State, captured product, flags and skid slot; all cleared asynchronously.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      rdy_en_q   <= 1'b0;
      prod_q     <= '0;
      c_q        <= 1'b0;
      z_q        <= 1'b0;
`ifdef MUL_WB_SKID_EN
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rdy_en_q   <= 1'b1;
      prod_q     <= prod_d;
      if (state_q == S_WR1) begin
        z_q <= (prod_q[15:0] == 16'h0000);
        c_q <= prod_q[16];
      end
`ifdef MUL_WB_SKID_EN
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
`endif
    end
  end

  // Next-state and product/skid capture.
  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
`ifdef MUL_WB_SKID_EN
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (w_hs) begin
          state_d = S_WR0;
          prod_d  = {i_c, i_r1, i_r0};
        end
`ifdef MUL_WB_SKID_EN
        // A product caught in the skid slot during the last WR1 still
        // needs its writeback (o_ready is low here, so no handshake).
        if (skid_vld_q) begin
          state_d    = S_WR0;
          prod_d     = skid_q;
          skid_vld_d = 1'b0;
        end
`endif
      end
      S_WR0: begin
        state_d = S_WR1;
`ifdef MUL_WB_SKID_EN
        if (w_hs) begin
          skid_d     = {i_c, i_r1, i_r0};
          skid_vld_d = 1'b1;
        end
`endif
      end
      S_WR1: begin
        state_d = S_IDLE;
`ifdef MUL_WB_SKID_EN
        // Handshake only happens with the slot empty, so these are exclusive.
        if (skid_vld_q) begin
          state_d    = S_WR0;
          prod_d     = skid_q;
          skid_vld_d = 1'b0;
        end
        if (w_hs) begin
          skid_d     = {i_c, i_r1, i_r0};
          skid_vld_d = 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register-file and flag strobes decoded from the current state.
  always_comb begin
    o_we      = 1'b0;
    o_waddr   = 5'd0;
    o_wdata   = 8'h00;
    o_flag_we = 1'b0;
    o_done    = 1'b0;
    case (state_q)
      S_WR0: begin
        o_we    = 1'b1;
        o_waddr = C_ADDR_LO;
        o_wdata = prod_q[7:0];
      end
      S_WR1: begin
        o_we      = 1'b1;
        o_waddr   = C_ADDR_HI;
        o_wdata   = prod_q[15:8];
        o_flag_we = 1'b1;
        o_done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_c = c_q;
  assign o_z = z_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_wb_stage
// Brief    : Directed self-checking bench for mul_wb_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_wb_stage;

  logic       clk;
  logic       rst;
  logic       valid;
  logic       valid31;
  logic [7:0] r1, r0;
  logic       c;

  logic       ready, we, flag_we, oc, oz, done;
  logic [4:0] waddr;
  logic [7:0] wdata;

  logic       ready31, we31, flag_we31, oc31, oz31, done31;
  logic [4:0] waddr31;
  logic [7:0] wdata31;

  int n_vec = 0;
  int n_err = 0;

  mul_wb_stage #(.P_BASE_ADDR(5'd0)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
    .i_r1(r1), .i_r0(r0), .i_c(c),
    .o_we(we), .o_waddr(waddr), .o_wdata(wdata),
    .o_flag_we(flag_we), .o_c(oc), .o_z(oz), .o_done(done)
  );

  mul_wb_stage #(.P_BASE_ADDR(5'd31)) dut31 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid31), .o_ready(ready31),
    .i_r1(r1), .i_r0(r0), .i_c(c),
    .o_we(we31), .o_waddr(waddr31), .o_wdata(wdata31),
    .o_flag_we(flag_we31), .o_c(oc31), .o_z(oz31), .o_done(done31)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One product through dut from an idle stage, checking both write cycles
  // and the flags afterwards. Inputs are trashed right after the handshake.
  task automatic wr_product(input string tag, input logic [7:0] a1, input logic [7:0] a0,
                            input logic ac, input logic ez, input logic ec);
    check_val({tag, "_pre_ready"}, ready, 1);
    r1 = a1; r0 = a0; c = ac; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; r1 = 8'hA5; r0 = 8'h5A; c = ~ac;
    check_val({tag, "_wr0_we"},    we, 1);
    check_val({tag, "_wr0_addr"},  waddr, 0);
    check_val({tag, "_wr0_data"},  wdata, a0);
    check_val({tag, "_wr0_done"},  done, 0);
    @(posedge clk); #1;
    check_val({tag, "_wr1_we"},    we, 1);
    check_val({tag, "_wr1_addr"},  waddr, 1);
    check_val({tag, "_wr1_data"},  wdata, a1);
    check_val({tag, "_wr1_fwe"},   flag_we, 1);
    check_val({tag, "_wr1_done"},  done, 1);
    check_val({tag, "_wr1_ready"}, ready, 0);
    @(posedge clk); #1;
    check_val({tag, "_idle_we"},   we, 0);
    check_val({tag, "_idle_addr"}, waddr, 0);
    check_val({tag, "_idle_data"}, wdata, 0);
    check_val({tag, "_idle_done"}, done, 0);
    check_val({tag, "_z"},         oz, ez);
    check_val({tag, "_c"},         oc, ec);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] prods [3];
    logic [4:0]  wa [8];
    logic [7:0]  wd [8];
    int          dt [4];
    int          nw, nd, idx, gap;
    logic        hs;

    rst = 1'b1; valid = 1'b0; valid31 = 1'b0; r1 = 8'h00; r0 = 8'h00; c = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ready", ready, 0);
    check_val("rst_we",    we, 0);
    check_val("rst_done",  done, 0);
    check_val("rst_z",     oz, 0);
    check_val("rst_c",     oc, 0);
    rst = 1'b0;
    #1;
    check_val("rst_rel_ready_hold", ready, 0);
    @(posedge clk); #1;
    check_val("rst_rel_ready", ready, 1);

    // ---------------- single product ----------------
    wr_product("single", 8'h40, 8'h80, 1'b0, 1'b0, 1'b0);

    // ---------------- zero product, flags hold ----------------
    wr_product("zero", 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
    r1 = 8'h77; r0 = 8'h66; c = 1'b0;   // no handshake: must be ignored
    repeat (3) @(posedge clk);
    #1;
    check_val("zero_hold_we", we, 0);
    check_val("zero_hold_z",  oz, 1);
    check_val("zero_hold_c",  oc, 1);

    // ---------------- back-pressure, 3 products ----------------
    prods[0] = {1'b0, 8'h12, 8'h34};
    prods[1] = {1'b0, 8'h56, 8'h78};
    prods[2] = {1'b1, 8'h9A, 8'hBC};
    idx = 0; nw = 0; nd = 0;
    {c, r1, r0} = prods[0];
    valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      hs = valid && ready;
      @(posedge clk); #1;
      if (hs) begin
        idx++;
        if (idx < 3) {c, r1, r0} = prods[idx];
        else valid = 1'b0;
      end
      if (we) begin
        if (nw < 8) begin wa[nw] = waddr; wd[nw] = wdata; end
        nw++;
`ifndef MUL_WB_SKID_EN
        check_val("bp_ready_busy", ready, 0);
`endif
      end
      if (done) begin
        if (nd < 4) dt[nd] = k;
        nd++;
      end
    end
`ifdef MUL_WB_SKID_EN
    gap = 2;
`else
    gap = 3;
`endif
    check_val("bp_nwrites", nw, 6);
    check_val("bp_ndone",   nd, 3);
    if (nw == 6) begin
      for (int p = 0; p < 3; p++) begin
        check_val("bp_addr_lo", wa[2*p],   0);
        check_val("bp_data_lo", wd[2*p],   prods[p][7:0]);
        check_val("bp_addr_hi", wa[2*p+1], 1);
        check_val("bp_data_hi", wd[2*p+1], prods[p][15:8]);
      end
    end
    if (nd == 3) begin
      check_val("bp_gap01", dt[1] - dt[0], gap);
      check_val("bp_gap12", dt[2] - dt[1], gap);
    end
    check_val("bp_z", oz, 0);
    check_val("bp_c", oc, 1);

    // ---------------- reset mid-operation ----------------
    @(posedge clk); #1;
    check_val("mid_pre_ready", ready, 1);
    r1 = 8'h12; r0 = 8'hFF; c = 1'b1; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    check_val("mid_wr0_we",   we, 1);
    check_val("mid_wr0_data", wdata, 8'hFF);
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_we",    we, 0);
    check_val("mid_rst_addr",  waddr, 0);
    check_val("mid_rst_data",  wdata, 0);
    check_val("mid_rst_done",  done, 0);
    check_val("mid_rst_z",     oz, 0);
    check_val("mid_rst_c",     oc, 0);
    check_val("mid_rst_ready", ready, 0);
    @(posedge clk); #1;
    check_val("mid_no_wr1_we", we, 0);
    rst = 1'b0;
    #1;
    check_val("mid_rel_ready_hold", ready, 0);
    @(posedge clk); #1;
    wr_product("after_rst", 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);

    // ---------------- address wrap (base 31) ----------------
    check_val("wrap_pre_ready", ready31, 1);
    r1 = 8'hC3; r0 = 8'h3C; c = 1'b0; valid31 = 1'b1;
    @(posedge clk); #1;
    valid31 = 1'b0;
    check_val("wrap_wr0_we",   we31, 1);
    check_val("wrap_wr0_addr", waddr31, 31);
    check_val("wrap_wr0_data", wdata31, 8'h3C);
    @(posedge clk); #1;
    check_val("wrap_wr1_we",   we31, 1);
    check_val("wrap_wr1_addr", waddr31, 0);
    check_val("wrap_wr1_data", wdata31, 8'hC3);
    check_val("wrap_wr1_done", done31, 1);
    @(posedge clk); #1;
    check_val("wrap_idle_we",  we31, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
